// File: rtl/dptr_mc.sv
//------------------------------------------------------------------------------
// Module   : dptr_mc
// Brief    : Multicycle R-type datapath (IDLE/READ/EXEC/WB) with register file,
//            preload port and zero/illegal flags. Optional macro DPTR_OVF_EN
//            adds TR_OF and suppresses writeback on signed add/sub overflow.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dptr_mc #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             ld_en,
  input  logic [4:0]       ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic [WIDTH-1:0] result,
  output logic             done,
`ifdef DPTR_OVF_EN
  output logic             TR_OF,
`endif
  output logic             TR_ZF,
  output logic             TR_ILL
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [5:0] c_ADD = 6'b100000;
  localparam logic [5:0] c_SUB = 6'b100010;
  localparam logic [5:0] c_AND = 6'b100100;
  localparam logic [5:0] c_OR  = 6'b100101;
  localparam logic [5:0] c_SLT = 6'b101010;
  localparam logic [5:0] c_SLL = 6'b000000;
  localparam logic [5:0] c_SRL = 6'b000010;

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, EXEC = 2'd2, WB = 2'd3} state_t;

  state_t           r_state, w_next;
  logic [31:0]      r_instr;
  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] r_opa, r_opb, r_alu;
  logic             r_ill;
  logic             r_ovf;

  logic [5:0]       w_op, w_funct;
  logic [4:0]       w_shamt;
  logic [AW-1:0]    w_rs, w_rt, w_rd, w_ld;
  logic [WIDTH-1:0] w_sum, w_dif, w_alu;
  logic             w_ill, w_ovf, w_lt, w_shbig, w_wr_ok;

  assign w_op    = r_instr[31:26];
  assign w_rs    = r_instr[21 +: AW];
  assign w_rt    = r_instr[16 +: AW];
  assign w_rd    = r_instr[11 +: AW];
  assign w_shamt = r_instr[10:6];
  assign w_funct = r_instr[5:0];
  assign w_ld    = ld_addr[AW-1:0];

  assign instr_ready = (r_state == IDLE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (instr_valid) w_next = READ;
      READ:    w_next = EXEC;
      EXEC:    w_next = WB;
      WB:      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_sum   = r_opa + r_opb;
  assign w_dif   = r_opa - r_opb;
  assign w_lt    = $signed(r_opa) < $signed(r_opb);
  assign w_shbig = ({27'd0, w_shamt} >= 32'(WIDTH));

  always_comb begin
    w_alu = '0;
    w_ill = 1'b0;
    if (w_op != 6'd0) begin
      w_ill = 1'b1;
    end else begin
      case (w_funct)
        c_ADD:   w_alu = w_sum;
        c_SUB:   w_alu = w_dif;
        c_AND:   w_alu = r_opa & r_opb;
        c_OR:    w_alu = r_opa | r_opb;
        c_SLT:   w_alu = {{(WIDTH-1){1'b0}}, w_lt};
        c_SLL:   w_alu = w_shbig ? '0 : (r_opb << w_shamt);
        c_SRL:   w_alu = w_shbig ? '0 : (r_opb >> w_shamt);
        default: w_ill = 1'b1;
      endcase
    end
  end

`ifdef DPTR_OVF_EN
  // Signed overflow: operands (b negated for sub) agree in sign, result does not.
  assign w_ovf = (w_op == 6'd0) &&
                 (((w_funct == c_ADD) && (r_opa[WIDTH-1] == r_opb[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != r_opa[WIDTH-1])) ||
                  ((w_funct == c_SUB) && (r_opa[WIDTH-1] != r_opb[WIDTH-1]) &&
                   (w_dif[WIDTH-1] != r_opa[WIDTH-1])));
  assign w_wr_ok = !r_ovf;
`else
  assign w_ovf   = 1'b0;
  assign w_wr_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_instr <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_alu   <= '0;
      r_ill   <= 1'b0;
      r_ovf   <= 1'b0;
      result  <= '0;
      done    <= 1'b0;
      TR_ZF   <= 1'b0;
      TR_ILL  <= 1'b0;
`ifdef DPTR_OVF_EN
      TR_OF   <= 1'b0;
`endif
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_next;
      done    <= 1'b0;
      TR_ILL  <= 1'b0;
`ifdef DPTR_OVF_EN
      TR_OF   <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          // Preload lands on the acceptance edge, so READ already sees it.
          if (ld_en && (w_ld != '0)) r_regs[w_ld] <= ld_data;
          if (instr_valid) r_instr <= instr;
        end
        READ: begin
          r_opa <= r_regs[w_rs];
          r_opb <= r_regs[w_rt];
        end
        EXEC: begin
          r_alu <= w_alu;
          r_ill <= w_ill;
          r_ovf <= w_ovf;
        end
        WB: begin
          done   <= 1'b1;
          TR_ILL <= r_ill;
`ifdef DPTR_OVF_EN
          TR_OF  <= r_ovf;
`endif
          if (!r_ill) begin
            result <= r_alu;
            TR_ZF  <= (r_alu == '0);
            if ((w_rd != '0) && w_wr_ok) r_regs[w_rd] <= r_alu;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dptr_mc.sv
//------------------------------------------------------------------------------
// Module   : tb_dptr_mc
// Brief    : Scoreboard bench for dptr_mc (reference model predicts each
//            instruction; results are checked when done pulses).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dptr_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        ld_en = 1'b0;
  logic [4:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [31:0] result;
  logic        done;
  logic        TR_ZF;
  logic        TR_ILL;
`ifdef DPTR_OVF_EN
  logic        TR_OF;
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  dptr_mc #(.WIDTH(32), .NREGS(32)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .result(result), .done(done),
`ifdef DPTR_OVF_EN
    .TR_OF(TR_OF),
`endif
    .TR_ZF(TR_ZF), .TR_ILL(TR_ILL)
  );

  typedef struct packed {
    logic [31:0] res;
    logic        zf;
    logic        ill;
    logic        of;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_regs [32];
  logic [31:0] m_res;
  logic        m_zf;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_res = '0;
    m_zf  = 1'b0;
  endtask

  task automatic model_step(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                            output exp_t e);
    logic [31:0] a, b, r;
    logic        ill, ov;
    a = m_regs[rs]; b = m_regs[rt]; r = '0; ill = 1'b0; ov = 1'b0;
    if (op != 6'd0) ill = 1'b1;
    else case (fn)
      6'h20: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      6'h22: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h2a: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h00: r = b << sh;
      6'h02: r = b >> sh;
      default: ill = 1'b1;
    endcase
    if (ill) begin
      e = '{res: m_res, zf: m_zf, ill: 1'b1, of: 1'b0};
    end else begin
      m_res = r;
      m_zf  = (r == 32'd0);
      e = '{res: r, zf: (r == 32'd0), ill: 1'b0, of: OVF_EN && ov};
      if (rd != 5'd0 && !(OVF_EN && ov)) m_regs[rd] = r;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    model_clear();
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
    if (a != 5'd0) m_regs[a] = d;
  endtask

  // Issue one instruction; with busy set, ld_en and a second instr are held
  // high while the datapath is busy and must both be ignored.
  task automatic run(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                     input bit busy, output logic [31:0] got);
    exp_t e;
    int   lat;
    bit   found;
    model_step(op, rs, rt, rd, sh, fn, e);
    sb.push_back(e);
    instr = {op, rs, rt, rd, sh, fn};
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    ld_en = 1'b0;
    if (busy) begin
      ld_en = 1'b1; ld_addr = 5'd20; ld_data = 32'hDEAD;
      instr = {6'd0, 5'd4, 5'd5, 5'd21, 5'd0, 6'h20};
      instr_valid = 1'b1;
    end
    found = 1'b0; lat = 0;
    for (int k = 1; k <= 8 && !found; k++) begin
      tick();
      if (done) begin found = 1'b1; lat = k; end
    end
    ld_en = 1'b0; instr_valid = 1'b0;
    e = sb.pop_front();
    got = result;
    n_vec++;
    if (!found || lat != 3) begin
      n_err++; $display("FAIL latency: got %0d cycles (found=%0d), required 3", lat, found);
    end
    n_vec++;
    if (result !== e.res) begin
      n_err++; $display("FAIL result instr=%h: got %h, required %h", {op, rs, rt, rd, sh, fn}, result, e.res);
    end
    n_vec++;
    if (TR_ZF !== e.zf) begin
      n_err++; $display("FAIL TR_ZF instr=%h: got %b, required %b", {op, rs, rt, rd, sh, fn}, TR_ZF, e.zf);
    end
    n_vec++;
    if (TR_ILL !== e.ill) begin
      n_err++; $display("FAIL TR_ILL instr=%h: got %b, required %b", {op, rs, rt, rd, sh, fn}, TR_ILL, e.ill);
    end
`ifdef DPTR_OVF_EN
    n_vec++;
    if (TR_OF !== e.of) begin
      n_err++; $display("FAIL TR_OF instr=%h: got %b, required %b", {op, rs, rt, rd, sh, fn}, TR_OF, e.of);
    end
`endif
  endtask

  // Read a register through "or rd=0 rs=a rt=0" and compare with a constant.
  task automatic readback(input logic [4:0] a, input logic [31:0] want, input string tag);
    logic [31:0] got;
    run(6'd0, a, 5'd0, 5'd0, 5'd0, 6'h25, 1'b0, got);
    n_vec++;
    if (got !== want) begin
      n_err++; $display("FAIL %s R%0d: got %h, required %h", tag, a, got, want);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL reset instr_ready: got %b, required 1", instr_ready); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset done: got %b, required 0", done); end
    n_vec++; if (result !== 32'd0) begin n_err++; $display("FAIL reset result: got %h, required 0", result); end
    n_vec++; if (TR_ZF !== 1'b0) begin n_err++; $display("FAIL reset TR_ZF: got %b, required 0", TR_ZF); end
    n_vec++; if (TR_ILL !== 1'b0) begin n_err++; $display("FAIL reset TR_ILL: got %b, required 0", TR_ILL); end
  endtask

  task automatic test_add();
    logic [31:0] got;
    preload(5'd4, 32'd5);
    preload(5'd5, 32'd5);
    run(6'd0, 5'd4, 5'd5, 5'd6, 5'd0, 6'h20, 1'b0, got);
    n_vec++; if (got !== 32'd10) begin n_err++; $display("FAIL add result: got %h, required 10", got); end
    readback(5'd6, 32'd10, "add wb");
  endtask

  task automatic test_alu_ops();
    logic [31:0] got;
    run(6'd0, 5'd4, 5'd5, 5'd7, 5'd0, 6'h22, 1'b0, got);
    n_vec++; if (got !== 32'd0 || TR_ZF !== 1'b1) begin n_err++; $display("FAIL sub: got %h zf %b, required 0 zf 1", got, TR_ZF); end
    run(6'd0, 5'd0, 5'd4, 5'd8, 5'd2, 6'h00, 1'b0, got);
    n_vec++; if (got !== 32'd20 || TR_ZF !== 1'b0) begin n_err++; $display("FAIL sll: got %h zf %b, required 14 zf 0", got, TR_ZF); end
    preload(5'd10, 32'hFFFF_FFFE);
    run(6'd0, 5'd10, 5'd4, 5'd11, 5'd0, 6'h2a, 1'b0, got);
    n_vec++; if (got !== 32'd1) begin n_err++; $display("FAIL slt neg: got %h, required 1", got); end
    run(6'd0, 5'd4, 5'd10, 5'd11, 5'd0, 6'h2a, 1'b0, got);
    n_vec++; if (got !== 32'd0) begin n_err++; $display("FAIL slt pos: got %h, required 0", got); end
    run(6'd0, 5'd0, 5'd10, 5'd12, 5'd4, 6'h02, 1'b0, got);
    n_vec++; if (got !== 32'h0FFF_FFFF) begin n_err++; $display("FAIL srl: got %h, required 0fffffff", got); end
    run(6'd0, 5'd10, 5'd4, 5'd13, 5'd0, 6'h24, 1'b0, got);
    n_vec++; if (got !== 32'd4) begin n_err++; $display("FAIL and: got %h, required 4", got); end
    run(6'd0, 5'd0, 5'd10, 5'd14, 5'd31, 6'h00, 1'b0, got);
  endtask

  task automatic test_r0();
    logic [31:0] got;
    run(6'd0, 5'd4, 5'd0, 5'd0, 5'd0, 6'h20, 1'b0, got);
    n_vec++; if (got !== 32'd5) begin n_err++; $display("FAIL rd0 result: got %h, required 5", got); end
    preload(5'd0, 32'd99);
    run(6'd0, 5'd0, 5'd0, 5'd1, 5'd0, 6'h25, 1'b0, got);
    n_vec++; if (got !== 32'd0 || TR_ZF !== 1'b1) begin n_err++; $display("FAIL R0 read: got %h zf %b, required 0 zf 1", got, TR_ZF); end
  endtask

  task automatic test_illegal();
    logic [31:0] got, prev_res;
    logic        prev_zf;
    prev_res = result; prev_zf = TR_ZF;
    run(6'd1, 5'd4, 5'd5, 5'd6, 5'd0, 6'h20, 1'b0, got);
    run(6'd0, 5'd4, 5'd5, 5'd6, 5'd0, 6'h3f, 1'b0, got);
    n_vec++; if (got !== prev_res || TR_ZF !== prev_zf) begin n_err++; $display("FAIL illegal hold: got %h zf %b, required %h zf %b", got, TR_ZF, prev_res, prev_zf); end
    readback(5'd6, 32'd10, "illegal no-wb");
  endtask

  task automatic test_overflow();
    logic [31:0] got;
    preload(5'd4, 32'h7FFF_FFFF);
    preload(5'd5, 32'd1);
    run(6'd0, 5'd4, 5'd5, 5'd6, 5'd0, 6'h20, 1'b0, got);
    n_vec++; if (got !== 32'h8000_0000) begin n_err++; $display("FAIL ovf result: got %h, required 80000000", got); end
    readback(5'd6, OVF_EN ? 32'd10 : 32'h8000_0000, "ovf wb");
  endtask

  task automatic test_ld_with_accept();
    logic [31:0] got;
    ld_en = 1'b1; ld_addr = 5'd15; ld_data = 32'h1234;
    m_regs[15] = 32'h1234;
    run(6'd0, 5'd15, 5'd0, 5'd16, 5'd0, 6'h25, 1'b0, got);
    n_vec++; if (got !== 32'h1234) begin n_err++; $display("FAIL ld+accept: got %h, required 1234", got); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got;
    int          extra;
    run(6'd0, 5'd4, 5'd5, 5'd17, 5'd0, 6'h25, 1'b1, got);
    extra = 0;
    for (int k = 0; k < 5; k++) begin tick(); if (done) extra++; end
    n_vec++; if (extra != 0) begin n_err++; $display("FAIL busy extra done: got %0d pulses, required 0", extra); end
    readback(5'd20, 32'd0, "busy ld ignored");
    readback(5'd21, 32'd0, "busy instr ignored");
  endtask

  task automatic test_reset_mid();
    int seen;
    instr = {6'd0, 5'd4, 5'd5, 5'd6, 5'd0, 6'h20};
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    rst = 1'b1; ld_en = 1'b1; ld_addr = 5'd4; ld_data = 32'd77;
    tick();
    rst = 1'b0; ld_en = 1'b0;
    model_clear();
    n_vec++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL mid-rst instr_ready: got %b, required 1", instr_ready); end
    n_vec++; if (result !== 32'd0 || TR_ZF !== 1'b0) begin n_err++; $display("FAIL mid-rst flags: got %h zf %b, required 0 zf 0", result, TR_ZF); end
    seen = (done === 1'b1) ? 1 : 0;
    for (int k = 0; k < 4; k++) begin tick(); if (done) seen++; end
    n_vec++; if (seen != 0) begin n_err++; $display("FAIL mid-rst done: got %0d pulses, required 0", seen); end
    readback(5'd4, 32'd0, "mid-rst R4");
    readback(5'd6, 32'd0, "mid-rst R6");
  endtask

  initial begin
    model_clear();
    test_reset();
    test_add();
    test_alu_ops();
    test_r0();
    test_illegal();
    test_overflow();
    test_ld_with_accept();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/dptr_mc.md
DPTR_MC -- requirements
Module: dptr_mc

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data width of registers, ALU and result.
REQ-002 Parameter NREGS, default 32, SHALL set the register count (power of 2, 2..32); register addresses SHALL use the low log2(NREGS) bits of each 5-bit field.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 instr  input  32  SHALL carry an R-type word {opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0]}.
REQ-006 instr_valid  input  1  SHALL mark instr as valid.
REQ-007 instr_ready  output  1  SHALL be high only in IDLE.
REQ-008 ld_en  input  1, ld_addr  input  5, ld_data  input  WIDTH  SHALL form the register preload port.
REQ-009 result  output  WIDTH  SHALL hold the last computed ALU result.
REQ-010 done  output  1  SHALL pulse for one cycle at instruction completion.
REQ-011 TR_ZF  output  1  SHALL be the registered zero flag of the last legal result.
REQ-012 TR_ILL  output  1  SHALL pulse with done when the instruction is illegal.

Function
REQ-013 FSM SHALL have states IDLE -> READ -> EXEC -> WB -> IDLE, one cycle each.
REQ-014 Acceptance SHALL occur when instr_valid && instr_ready; instr SHALL be latched and FSM SHALL move to READ.
REQ-015 READ SHALL latch R[rs] and R[rt] into operand registers; EXEC SHALL compute and register the ALU result; WB SHALL write back and assert done.
REQ-016 Latency SHALL be exactly 3 cycles from the acceptance edge to done high; throughput SHALL be one instruction per 4 cycles.
REQ-017 funct SHALL decode as 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed, result 1 or 0), 000000 sll (R[rt] << shamt), 000010 srl (R[rt] >> shamt, logical).
REQ-018 Arithmetic SHALL be modulo 2^WIDTH; shift amounts >= WIDTH SHALL give 0.
REQ-019 opcode != 000000 or an unlisted funct SHALL be illegal: no writeback, TR_ILL=1 with done, and result and TR_ZF unchanged.
REQ-020 Register 0 SHALL always read 0; writes to address 0 SHALL be discarded, but result and TR_ZF SHALL still update.
REQ-021 TR_ZF SHALL update in WB to (result == 0) for legal instructions only.
REQ-022 ld_en SHALL write ld_data to R[ld_addr] only in IDLE; ld_en SHALL be ignored in other states.
REQ-023 If ld_en and acceptance occur in the same cycle, the preload SHALL complete first and READ SHALL see the preloaded value.
REQ-024 instr_valid outside IDLE SHALL be ignored, and the held instruction SHALL NOT be consumed twice.

Reset
REQ-025 rst SHALL force IDLE and clear all registers R[0..NREGS-1], result, done, TR_ZF and TR_ILL to 0.
REQ-026 rst asserted mid-instruction SHALL abort it with no writeback and no done pulse; rst SHALL take priority over ld_en and acceptance.

Configuration
REQ-027 With DPTR_OVF_EN defined, output TR_OF (1 bit) SHALL exist and pulse with done on signed overflow of add or sub; in that case writeback SHALL be suppressed, while result and TR_ZF SHALL update.
REQ-028 Without DPTR_OVF_EN, TR_OF SHALL NOT exist, and overflowing add or sub SHALL write back the wrapped result.

Verification
REQ-029 Reset, preload R4=5 and R5=5, run add rd=6 rs=4 rt=5 (funct 100000) -> done exactly 3 cycles after acceptance, R6=10, TR_ZF=0.
REQ-030 Run sub rd=7 rs=4 rt=5 -> result=0, TR_ZF=1; then run sll rd=8 rt=4 shamt=2 -> result=20, TR_ZF=0.
REQ-031 Run add with rd=0 and rs=R4=5 -> result=5, and R0 still reads 0 on a following or rs=0 rt=0 (result=0).
REQ-032 Run opcode=000001 or funct=111111 -> TR_ILL and done pulse together, and TR_ZF and the register file are unchanged.
REQ-033 Preload R4=0x7FFFFFFF and R5=1, run add rd=6 -> with DPTR_OVF_EN: TR_OF=1 and R6 unchanged; without it: R6=0x80000000.
REQ-034 Assert rst during EXEC -> no done pulse, instr_ready=1 the next cycle, all registers read 0.
